hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: REG_AW, 4, register address width.
REQ-002 Parameter: DEPTH, 3, tracked post-ID stages (0=EX, 1=MEM, 2=WB, ...), range 2..8.
REQ-003 Parameter: ALU_RDY, 0, first stage index whose ALU result may be forwarded.
REQ-004 Parameter: LD_RDY, 1, first stage index whose load data may be forwarded; LD_RDY >= ALU_RDY.
REQ-005 Parameter: SW, $clog2(DEPTH+1), forward-select width.
REQ-006 Clk  in  1  single clock, rising edge.
REQ-007 Rst  in  1  reset, synchronous and active-high.
REQ-008 id_valid  in  1  ID holds a valid instruction.
REQ-009 id_src1 / id_src2  in  REG_AW  source register numbers.
REQ-010 id_use1 / id_use2  in  1  source actually read (0 for immediate/unused).
REQ-011 id_dst  in  REG_AW  destination register.
REQ-012 id_regwrite  in  1  instruction writes id_dst.
REQ-013 id_memread  in  1  instruction is a load.
REQ-014 flush  in  1  squash the ID instruction (branch taken).
REQ-015 stall  out  1  hold PC and IF/ID; bubble into EX.
REQ-016 issue  out  1  ID instruction enters stage 0 this edge.
REQ-017 fwd_sel1 / fwd_sel2  out  SW  0 = register file, k+1 = result of stage k.
REQ-018 stall_cnt  out  16  saturating stall-cycle counter (see Configuration).

Function
REQ-019 Per stage k, one entry SHALL hold: v, we, ld, dst.
REQ-020 Every Clk edge, entry k SHALL move to k+1; entry DEPTH-1 SHALL be discarded; no hold of the table ever.
REQ-021 Stage 0 SHALL load {1, id_regwrite, id_memread, id_dst} when issue=1, else v=0 (bubble).
REQ-022 Entry k SHALL match source s when v & we & dst==s & s!=0 & use=1.
REQ-023 For each source, the lowest-index matching stage k SHALL be selected; fwd_sel = k+1; no match -> 0.
REQ-024 Selected entry SHALL be ready when k >= (ld ? LD_RDY : ALU_RDY).
REQ-025 hazard SHALL be 1 when either source selects a not-ready entry.
REQ-026 stall = id_valid & hazard & ~flush; issue = id_valid & ~stall & ~flush.
REQ-027 stall, issue, fwd_sel SHALL be combinational from current table and ID inputs; same-cycle.
REQ-028 Register 0 SHALL never match, stall or forward.
REQ-029 An older match in a higher stage SHALL be ignored when a younger match exists.
REQ-030 Entries with we=0 SHALL never match, even when dst equals a source.
REQ-031 Load-use distance 1 with defaults SHALL produce exactly one stall cycle, then fwd_sel=2.
REQ-032 flush together with hazard SHALL yield stall=0, issue=0, bubble inserted.
REQ-033 fwd_sel SHALL remain valid during stall; consumers ignore it when issue=0.

Reset
REQ-034 Rst=1 at an edge SHALL clear all entry v bits; Rst overrides issue at that edge.
REQ-035 After reset, stall=0, fwd_sel1=fwd_sel2=0, issue=id_valid & ~flush.
REQ-036 Rst mid-stall SHALL drop all pending hazards next cycle.

Configuration
REQ-037 Macro HAZARD_SCOREBOARD_PERF_EN defined: stall_cnt increments each edge with stall=1, saturates at 16'hFFFF, cleared by Rst.
REQ-038 Macro undefined: stall_cnt SHALL be constant 0 and no counter flop SHALL be inferred.

Verification
REQ-039 load r3 then add r5,r3,r4 back-to-back -> stall=1 one cycle, next cycle fwd_sel1=2, issue=1.
REQ-040 add r3 then sub r6,r3,r3 -> stall=0, fwd_sel1=fwd_sel2=1.
REQ-041 add r3, add r3, add r7,r3,r0 -> fwd_sel1=1 (youngest), fwd_sel2=0.
REQ-042 load r0 then add r1,r0,r0 -> stall=0, fwd_sel=0.
REQ-043 load r2, then use of r2 with flush=1 -> stall=0, issue=0, stage 0 bubble.
REQ-044 PERF_EN, 3 load-use pairs then Rst -> stall_cnt=3, then 0 after reset.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks in-flight destinations, picks forwarding sources, stalls on unready results.
// Optional stall-cycle counter is built when HAZARD_SCOREBOARD_PERF_EN is defined.
module hazard_scoreboard #(
    parameter int REG_AW  = 4,
    parameter int DEPTH   = 3,
    parameter int ALU_RDY = 0,
    parameter int LD_RDY  = 1,
    parameter int SW      = $clog2(DEPTH + 1)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              stall,
    output logic              issue,
    output logic [SW-1:0]     fwd_sel1,
    output logic [SW-1:0]     fwd_sel2,
    output logic [15:0]       stall_cnt
);

    logic [DEPTH-1:0]  ent_v;
    logic [DEPTH-1:0]  ent_we;
    logic [DEPTH-1:0]  ent_ld;
    logic [REG_AW-1:0] ent_dst [DEPTH];

    logic not_rdy1, not_rdy2, hazard;

    function automatic logic unready(input int k, input logic ld);
        return ld ? (k < LD_RDY) : (k < ALU_RDY);
    endfunction

    // Scan from oldest to youngest so the lowest-index (youngest) match wins.
    always_comb begin
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        not_rdy1 = 1'b0;
        not_rdy2 = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_v[k] && ent_we[k] && id_use1 && (id_src1 != '0) && (ent_dst[k] == id_src1)) begin
                fwd_sel1 = SW'(k + 1);
                not_rdy1 = unready(k, ent_ld[k]);
            end
            if (ent_v[k] && ent_we[k] && id_use2 && (id_src2 != '0) && (ent_dst[k] == id_src2)) begin
                fwd_sel2 = SW'(k + 1);
                not_rdy2 = unready(k, ent_ld[k]);
            end
        end
    end

    assign hazard = not_rdy1 | not_rdy2;
    assign stall  = id_valid & hazard & ~flush;
    assign issue  = id_valid & ~stall & ~flush;

    // Stage boundary: table advances every edge, stage 0 takes the issued instruction or a bubble.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ent_v <= '0;
        end else begin
            ent_v <= {ent_v[DEPTH-2:0], issue};
        end
    end

    always_ff @(posedge Clk) begin
        ent_we     <= {ent_we[DEPTH-2:0], id_regwrite};
        ent_ld     <= {ent_ld[DEPTH-2:0], id_memread};
        ent_dst[0] <= id_dst;
        for (int k = 1; k < DEPTH; k++) begin
            ent_dst[k] <= ent_dst[k-1];
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [15:0] cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt <= '0;
        end else if (stall) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
